// File: rtl/serial_comparator_msb.sv
// Bit-serial magnitude comparator, MSB first.
// Scans operand pairs from the most significant bit down and latches the
// first differing pair; the registered EQ/GT/LT flags are published together
// with a one-cycle done strobe once WIDTH pairs have been accepted.
module serial_comparator_msb #(
   parameter int WIDTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic clear,
   input  logic bit_valid,
   input  logic a_bit,
   input  logic b_bit,
   output logic busy,
   output logic done,
   output logic eq,
   output logic gt,
   output logic lt
);

   // Counter only needs to hold WIDTH down to 0; it exits RUN at 0 and never wraps.
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          decided_q, decided_d;
   logic          pend_gt_q, pend_gt_d;
   logic          eq_q, eq_d;
   logic          gt_q, gt_d;
   logic          lt_q, lt_d;

   // Decision including the pair on the inputs this cycle; the first
   // difference wins and later pairs cannot overturn it.
   logic dec_now;
   logic pg_now;
   assign dec_now = decided_q | (a_bit ^ b_bit);
   assign pg_now  = decided_q ? pend_gt_q : a_bit;

   // Next-state logic: clear dominates, then the IDLE/RUN/DONE sequencing.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      decided_d = decided_q;
      pend_gt_d = pend_gt_q;
      eq_d      = eq_q;
      gt_d      = gt_q;
      lt_d      = lt_q;

      if (clear) begin
         // Abort without touching the last published result.
         state_d = S_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d   = S_RUN;
                  cnt_d     = CNT_LOAD;
                  decided_d = 1'b0;
                  pend_gt_d = 1'b0;
               end
            end
            S_RUN: begin
               if (bit_valid) begin
                  cnt_d     = cnt_q - CNT_ONE;
                  decided_d = dec_now;
                  pend_gt_d = pg_now;
                  if (cnt_q == CNT_ONE) begin
                     // Last pair: publish the flags on the same edge that enters DONE.
                     state_d = S_DONE;
                     eq_d    = ~dec_now;
                     gt_d    = dec_now & pg_now;
                     lt_d    = dec_now & ~pg_now;
                  end
               end
            end
            S_DONE: begin
               if (start) begin
                  // Back-to-back operation: skip IDLE entirely.
                  state_d   = S_RUN;
                  cnt_d     = CNT_LOAD;
                  decided_d = 1'b0;
                  pend_gt_d = 1'b0;
               end else begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // State and result registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         decided_q <= 1'b0;
         pend_gt_q <= 1'b0;
         eq_q      <= 1'b0;
         gt_q      <= 1'b0;
         lt_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         decided_q <= decided_d;
         pend_gt_q <= pend_gt_d;
         eq_q      <= eq_d;
         gt_q      <= gt_d;
         lt_q      <= lt_d;
      end
   end

   assign busy = (state_q == S_RUN);
   assign done = (state_q == S_DONE);
   assign eq   = eq_q;
   assign gt   = gt_q;
   assign lt   = lt_q;

endmodule
